mux4_rr_arbiter: RTL and testbench
==================================

# mux4_rr_arbiter

Round-robin arbiter and sequencer for the shared 4:1 data multiplexer. Accepts up to four requesters, grants one at a time, and drives the mux select from the grant. Registers the selected data toward a single downstream consumer with a valid/ready beat handshake. Bounds each grant to a maximum burst length so no requester can starve the others.

## Interface
- DW, 8, data width of every requester input and of dout
- HOLD_MAX, 4, max beats per grant while another requester is waiting; legal range 1..15
- clk  input  1  single clock, all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- req  input  4  request, one bit per requester; must stay high for the duration of a burst
- din0..din3  input  DW  requester data, sampled only when that requester is granted
- ready  input  1  downstream can accept a beat this cycle
- gnt  output  4  one-hot grant, all-zero when idle
- sel  output  2  mux select equal to the index of the granted requester
- dout  output  DW  registered selected data
- dout_valid  output  1  dout carries a new beat this cycle
- busy  output  1  high while in GRANT

## Operation
- States: IDLE, GRANT. Reset → IDLE.
- Reset values: gnt=0000, sel=00, dout=0, dout_valid=0, busy=0. Internal: rr pointer=0, beat count=0.
- IDLE: if req≠0, pick the first set bit scanning from pointer upward with wrap (3→0). At the next edge, load gnt/sel, set busy, clear count, and enter GRANT. If req=0, stay in IDLE with all outputs at reset values, except that dout holds.
- GRANT beat: this occurs in a cycle where req[sel]=1 and ready=1. At the edge, dout ← din[sel] and dout_valid ← 1. Count increments, saturating at HOLD_MAX.
- Any cycle without a beat: dout_valid ← 0 and dout holds. dout_valid is a one-cycle pulse per beat.
- Release: triggered if req[sel]=0, or if count reaches HOLD_MAX while some other req bit is set. At that edge, gnt ← 0, sel holds, busy ← 0, pointer ← sel+1 (mod 4), and the state goes to IDLE.
- Beat on the release cycle: the beat that makes count=HOLD_MAX is still delivered.
- Lone requester: if count reaches HOLD_MAX and no other req is pending, count clears and the grant continues with no bubble.
- req[sel] drop mid-burst: no beat that cycle, and release occurs at that edge.
- Requests from non-granted requesters never affect dout.
- ready may toggle freely. Beats are neither lost nor duplicated; a beat exists only in a cycle where ready=1.
- Reset mid-burst: everything returns to reset values at the edge. An in-flight beat is dropped.

## Timing
- req rises in IDLE at cycle n → gnt/sel valid at n+1 → first dout_valid at n+2, provided ready=1 at n+1.
- Throughput while granted: 1 beat/cycle.
- Requester switch costs exactly one IDLE bubble cycle.
- sel is stable for the whole grant and is registered, with no combinational path from req.
- dout/dout_valid are registered with no combinational path from ready.

## Configuration
- MUXARB_FIXED_PRIO_EN defined:
  - Fixed priority, req[0] highest. The pointer is ignored and always treated as 0.
  - HOLD_MAX preemption is disabled; a grant ends only when req[sel] drops.
- MUXARB_FIXED_PRIO_EN undefined: round-robin with HOLD_MAX preemption, as specified above.

## Structure
- Shared package mux_arb_pkg holds:
  - NREQ=4, SEL_W=2
  - state enum {IDLE, GRANT}
  - grant-to-index encode function, used by both RTL and bench
- One sub-module, mux4_sel_dp: purely combinational 4:1 selector built from three 2:1 stages, driven by sel. The arbiter registers its output into dout.

## Test plan
- Single requester: req=0001, din0=8'hA5, ready=1 held. Expect gnt=0001 and sel=00 at cycle 1, dout=A5 with dout_valid=1 from cycle 2 onward, and no release while req0 stays high.
- Round-robin rotation: req=1111 steady, ready=1, HOLD_MAX=4. Expect grants in order 0,1,2,3,0; 4 beats each; one idle bubble between grants.
- Backpressure: req=0100, ready toggles 1,0,0,1. Expect exactly 2 beats from din2, and dout_valid low during both ready=0 cycles.
- Early drop: requester 1 granted, req1 falls after 2 beats. Expect release at that edge, pointer=2, and next grant to requester 3 when req=1001.
- Reset mid-burst: rst=1 for one cycle during a GRANT with count=2. Expect all outputs at reset values the next cycle and re-arbitration starting from requester 0.
- With MUXARB_FIXED_PRIO_EN: req=1111 steady. Expect gnt=0001 held indefinitely, with no preemption after HOLD_MAX beats.

Source files
------------

// File: rtl/mux_arb_pkg.sv
// Shared constants, FSM state type and grant encoder for the 4:1 mux arbiter.
package mux_arb_pkg;
   localparam int NREQ  = 4;
   localparam int SEL_W = 2;

   typedef enum logic {IDLE, GRANT} state_t;

   // One-hot grant to requester index; zero grant encodes to 0.
   function automatic logic [SEL_W-1:0] gnt2idx(input logic [NREQ-1:0] g);
      logic [SEL_W-1:0] r;
      r = '0;
      for (int i = 0; i < NREQ; i++)
         if (g[i]) r = i[SEL_W-1:0];
      return r;
   endfunction
endpackage

// File: rtl/mux4_sel_dp.sv
// Combinational 4:1 data selector built from three 2:1 stages.
module mux4_sel_dp #(
   parameter int DW = 8
) (
   input  logic [1:0]    i_sel,
   input  logic [DW-1:0] i_d0,
   input  logic [DW-1:0] i_d1,
   input  logic [DW-1:0] i_d2,
   input  logic [DW-1:0] i_d3,
   output logic [DW-1:0] o_q
);
   logic [DW-1:0] w_lo;
   logic [DW-1:0] w_hi;

   assign w_lo = i_sel[0] ? i_d1 : i_d0;
   assign w_hi = i_sel[0] ? i_d3 : i_d2;
   assign o_q  = i_sel[1] ? w_hi : w_lo;
endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter driving a shared 4:1 mux with registered valid/ready beats.
// Define MUXARB_FIXED_PRIO_EN for fixed priority (req[0] highest) without burst preemption.
module mux4_rr_arbiter
   import mux_arb_pkg::*;
#(
   parameter int DW       = 8,
   parameter int HOLD_MAX = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [3:0]    req,
   input  logic [DW-1:0] din0,
   input  logic [DW-1:0] din1,
   input  logic [DW-1:0] din2,
   input  logic [DW-1:0] din3,
   input  logic          ready,
   output logic [3:0]    gnt,
   output logic [1:0]    sel,
   output logic [DW-1:0] dout,
   output logic          dout_valid,
   output logic          busy
);
   state_t           r_state;
   logic [NREQ-1:0]  r_gnt;
   logic [SEL_W-1:0] r_sel;
   logic [SEL_W-1:0] r_ptr;
   logic [3:0]       r_cnt;
   logic [DW-1:0]    r_dout;
   logic             r_dout_valid;
   logic             r_busy;

   logic [DW-1:0]    w_mux;
   logic [NREQ-1:0]  w_pick;
   logic [SEL_W-1:0] w_base;
   logic             w_beat;
   logic             w_hit;
   logic             w_preempt;
   logic             w_release;

   mux4_sel_dp #(.DW(DW)) u_dp (
      .i_sel (r_sel),
      .i_d0  (din0),
      .i_d1  (din1),
      .i_d2  (din2),
      .i_d3  (din3),
      .o_q   (w_mux)
   );

`ifdef MUXARB_FIXED_PRIO_EN
   assign w_base    = '0;
   assign w_preempt = 1'b0;
`else
   logic w_others;
   assign w_base    = r_ptr;
   assign w_others  = |(req & ~r_gnt);
   assign w_preempt = w_hit & w_others;
`endif

   // First set request scanning upward from the base index with wrap.
   always_comb begin : p_pick
      logic [SEL_W-1:0] w_idx;
      logic             w_found;
      w_pick  = '0;
      w_idx   = '0;
      w_found = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
         w_idx = w_base + i[SEL_W-1:0];
         if (!w_found && req[w_idx]) begin
            w_pick[w_idx] = 1'b1;
            w_found       = 1'b1;
         end
      end
   end

   assign w_beat    = (r_state == GRANT) & req[r_sel] & ready;
   // The beat that brings the count to HOLD_MAX is still delivered on that edge.
   assign w_hit     = w_beat & (({1'b0, r_cnt} + 5'd1) >= 5'(HOLD_MAX));
   assign w_release = ~req[r_sel] | w_preempt;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= IDLE;
         r_gnt        <= '0;
         r_sel        <= '0;
         r_ptr        <= '0;
         r_cnt        <= '0;
         r_dout       <= '0;
         r_dout_valid <= 1'b0;
         r_busy       <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               r_dout_valid <= 1'b0;
               if (|req) begin
                  r_gnt   <= w_pick;
                  r_sel   <= gnt2idx(w_pick);
                  r_busy  <= 1'b1;
                  r_cnt   <= '0;
                  r_state <= GRANT;
               end else begin
                  r_gnt  <= '0;
                  r_sel  <= '0;
                  r_busy <= 1'b0;
               end
            end
            GRANT: begin
               r_dout_valid <= w_beat;
               if (w_beat) begin
                  r_dout <= w_mux;
                  r_cnt  <= w_hit ? 4'd0 : r_cnt + 4'd1;
               end
               if (w_release) begin
                  r_gnt   <= '0;
                  r_busy  <= 1'b0;
                  r_ptr   <= r_sel + SEL_W'(1);
                  r_state <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign gnt        = r_gnt;
   assign sel        = r_sel;
   assign dout       = r_dout;
   assign dout_valid = r_dout_valid;
   assign busy       = r_busy;
endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Self-checking bench for mux4_rr_arbiter: directed scenarios plus random traffic
// compared cycle by cycle against a behavioural arbitration model.
module tb_mux4_rr_arbiter;
   import mux_arb_pkg::*;

   localparam int DW = 8;
   localparam int HM = 4;
`ifdef MUXARB_FIXED_PRIO_EN
   localparam bit FIXED = 1'b1;
`else
   localparam bit FIXED = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst;
   logic [3:0]    req;
   logic [DW-1:0] din0, din1, din2, din3;
   logic          ready;
   logic [3:0]    gnt;
   logic [1:0]    sel;
   logic [DW-1:0] dout;
   logic          dout_valid;
   logic          busy;

   mux4_rr_arbiter #(.DW(DW), .HOLD_MAX(HM)) dut (
      .clk(clk), .rst(rst), .req(req),
      .din0(din0), .din1(din1), .din2(din2), .din3(din3),
      .ready(ready), .gnt(gnt), .sel(sel), .dout(dout),
      .dout_valid(dout_valid), .busy(busy)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Behavioural model: who holds the mux, how many beats it has had, what was last delivered.
   bit            m_busy;
   int            m_idx, m_ptr, m_cnt;
   logic [1:0]    m_sel;
   logic [DW-1:0] m_dout;
   bit            m_valid;

   task automatic model_step();
      logic [DW-1:0] d [4];
      bit beat, others, found;
      int base, j;
      d = '{din0, din1, din2, din3};
      if (rst) begin
         m_busy = 0; m_idx = 0; m_ptr = 0; m_cnt = 0;
         m_sel = '0; m_dout = '0; m_valid = 0;
         return;
      end
      if (!m_busy) begin
         m_valid = 0;
         if (req != 4'b0) begin
            base  = FIXED ? 0 : m_ptr;
            found = 0;
            for (int k = 0; k < 4; k++) begin
               j = (base + k) % 4;
               if (!found && req[j]) begin
                  m_idx = j;
                  found = 1;
               end
            end
            m_busy = 1;
            m_cnt  = 0;
            m_sel  = gnt2idx(4'(1 << m_idx));
         end else begin
            m_sel = '0;
         end
      end else begin
         beat   = req[m_idx] && ready;
         others = (req & ~(4'(1 << m_idx))) != 4'b0;
         if (beat) begin
            m_dout  = d[m_idx];
            m_valid = 1;
            m_cnt++;
         end else begin
            m_valid = 0;
         end
         if (!req[m_idx]) begin
            m_busy = 0;
            m_ptr  = (m_idx + 1) % 4;
         end else if (beat && m_cnt >= HM) begin
            if (others && !FIXED) begin
               m_busy = 0;
               m_ptr  = (m_idx + 1) % 4;
            end else begin
               m_cnt = 0;
            end
         end
      end
   endtask

   int        beats;
   logic [3:0] prev_gnt;
   int        gq[$];

   task automatic step();
      @(posedge clk);
      model_step();
      #1;
      chk("gnt",   32'(gnt),        m_busy ? 32'(1 << m_idx) : 32'd0);
      chk("sel",   32'(sel),        32'(m_sel));
      chk("valid", 32'(dout_valid), 32'(m_valid));
      chk("dout",  32'(dout),       32'(m_dout));
      chk("busy",  32'(busy),       32'(m_busy));
      if (dout_valid) beats++;
      if (gnt != 4'b0 && prev_gnt == 4'b0) gq.push_back(int'(gnt2idx(gnt)));
      prev_gnt = gnt;
   endtask

   task automatic do_reset();
      rst = 1'b1; req = '0; ready = 1'b0;
      step();
      step();
      rst = 1'b0;
      beats = 0;
      gq.delete();
   endtask

   initial begin
      m_busy = 0; m_idx = 0; m_ptr = 0; m_cnt = 0;
      m_sel = '0; m_dout = '0; m_valid = 0;
      prev_gnt = '0; beats = 0;
      rst = 1'b1; req = '0; ready = 1'b0;
      din0 = 8'h11; din1 = 8'h22; din2 = 8'h33; din3 = 8'h44;

      // Reset state
      do_reset();
      chk("rst_gnt", 32'(gnt), 32'd0);
      chk("rst_dout", 32'(dout), 32'd0);

      // Single requester streams without release
      din0 = 8'hA5; req = 4'b0001; ready = 1'b1;
      repeat (10) step();
      chk("single_gnt", 32'(gnt), 32'd1);
      chk("single_dout", 32'(dout), 32'hA5);
      chk("single_beats", 32'(beats), 32'd9);

      // Rotation with all requesters active
      do_reset();
      req = 4'b1111; ready = 1'b1;
      repeat (30) step();
      if (FIXED) begin
         chk("fix_ngrants", 32'(gq.size()), 32'd1);
         chk("fix_gnt", 32'(gnt), 32'd1);
      end else if (gq.size() >= 5) begin
         chk("rot0", 32'(gq[0]), 32'd0);
         chk("rot1", 32'(gq[1]), 32'd1);
         chk("rot2", 32'(gq[2]), 32'd2);
         chk("rot3", 32'(gq[3]), 32'd3);
         chk("rot4", 32'(gq[4]), 32'd0);
      end else begin
         chk("rot_ngrants", 32'(gq.size()), 32'd5);
      end

      // Backpressure: ready 1,0,0,1 gives exactly two beats
      do_reset();
      req = 4'b0100; ready = 1'b1;
      step();
      ready = 1'b1; step();
      ready = 1'b0; step();
      chk("bp_valid_lo1", 32'(dout_valid), 32'd0);
      step();
      chk("bp_valid_lo2", 32'(dout_valid), 32'd0);
      ready = 1'b1; step();
      req = 4'b0000; step();
      step();
      chk("bp_beats", 32'(beats), 32'd2);
      chk("bp_dout", 32'(dout), 32'h33);

      // Early drop of requester 1 moves the pointer to 2
      do_reset();
      req = 4'b0010; ready = 1'b1;
      step(); step(); step();
      req = 4'b1001;
      step();
      chk("drop_release", 32'(gnt), 32'd0);
      step();
      chk("drop_next", 32'(gnt), FIXED ? 32'd1 : 32'd8);

      // Reset in the middle of a burst
      do_reset();
      req = 4'b1111; ready = 1'b1;
      step(); step(); step();
      rst = 1'b1;
      step();
      chk("mid_rst_gnt", 32'(gnt), 32'd0);
      chk("mid_rst_valid", 32'(dout_valid), 32'd0);
      chk("mid_rst_dout", 32'(dout), 32'd0);
      rst = 1'b0;
      step();
      chk("mid_rst_regrant", 32'(gnt), 32'd1);

      // Random traffic
      for (int c = 0; c < 600; c++) begin
         if ($urandom_range(0, 3) == 0) req[$urandom_range(0, 3)] ^= 1'b1;
         ready = ($urandom_range(0, 3) != 0);
         din0  = DW'($urandom); din1 = DW'($urandom);
         din2  = DW'($urandom); din3 = DW'($urandom);
         rst   = ($urandom_range(0, 99) == 0);
         step();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
